flash_seq_ctrl: RTL and testbench

- Sequences the flash erase, program and read engines over a configurable sector range, then compares the read-back data against the expected pattern.
- Issues one request at a time to each engine and tracks its busy handshake. Times out hung operations, keeps pass and error counters, and reports a status code.
- Sits between the board test top level and the three flash engine blocks. Replaces free-running state sequencing with a bounded, verifiable one.

---
 rtl/flash_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_flash_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_seq_ctrl.sv
// Flash erase/program/read sequencer with per-operation ack and completion timeouts.
// Build option FLASH_SEQ_READLOOP_EN: after the first full pass, read-verify the range forever.
module flash_seq_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int LAST_ADDR   = 15,
  parameter int ACK_CYC     = 16,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic              CLK50M,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  output logic              erase_req,
  input  logic              erasing,
  output logic              prog_req,
  input  logic              proging,
  output logic              read_req,
  input  logic              reading,
  input  logic              rd_mismatch,
  output logic [ADDR_W-1:0] sector,
  output logic [3:0]        state,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic [1:0]        status,
  output logic              done
);

  // state   | meaning
  // IDLE    | waiting for start
  // ERASE   | erase_req pulse
  // ERASE_W | waiting for erase engine ack and completion
  // PROG    | prog_req pulse
  // PROG_W  | waiting for program engine ack and completion
  // READ    | read_req pulse
  // READ_W  | waiting for read engine; latches rd_mismatch on completion
  // CHECK   | bump pass or error counter
  // NEXT    | advance sector or finish
  // DONE    | run complete, status holds verify result
  // FAULT   | engine timed out; frozen until abort or reset
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ERASE   = 4'd1,
    S_ERASE_W = 4'd2,
    S_PROG    = 4'd3,
    S_PROG_W  = 4'd4,
    S_READ    = 4'd5,
    S_READ_W  = 4'd6,
    S_CHECK   = 4'd7,
    S_NEXT    = 4'd8,
    S_DONE    = 4'd9,
    S_FAULT   = 4'd10
  } state_e;

  localparam int ACK_W = $clog2(ACK_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  // Timers load on the cycle after the req pulse, so the terminal count lands
  // exactly ACK_CYC / TIMEOUT_CYC cycles after req rose (needs both >= 2).
  localparam logic [ACK_W-1:0]  ACK_LOAD = ACK_W'(ACK_CYC - 2);
  localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT_CYC - 2);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);

  logic              rst_meta_q;
  logic              rst_sync_q;
  state_e            state_q;
  logic [ADDR_W-1:0] sector_q;
  logic              erase_req_q;
  logic              prog_req_q;
  logic              read_req_q;
  logic [15:0]       pass_cnt_q;
  logic [15:0]       err_cnt_q;
  logic [1:0]        status_q;
  logic              done_q;
  logic              busy_seen_q;
  logic              mism_q;
  logic [ACK_W-1:0]  ack_tmr_q;
  logic [TO_W-1:0]   op_tmr_q;
`ifdef FLASH_SEQ_READLOOP_EN
  logic              loop_q;
`endif

  logic busy_sel;
  logic ack_now;
  logic op_cmpl;
  logic ack_expired;
  logic op_expired;

  // Reset asserts immediately, releases two clocks later in the CLK50M domain.
  always_ff @(posedge CLK50M or negedge RST) begin
    if (!RST) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  always_comb begin
    busy_sel = 1'b0;
    case (state_q)
      S_ERASE_W: busy_sel = erasing;
      S_PROG_W:  busy_sel = proging;
      S_READ_W:  busy_sel = reading;
      default:   busy_sel = 1'b0;
    endcase
  end

  assign ack_now     = busy_seen_q | busy_sel;
  assign op_cmpl     = busy_seen_q & ~busy_sel;
  assign ack_expired = ~ack_now & (ack_tmr_q == '0);
  assign op_expired  = (op_tmr_q == '0);

  always_ff @(posedge CLK50M or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q     <= S_IDLE;
      sector_q    <= BASE_A;
      erase_req_q <= 1'b0;
      prog_req_q  <= 1'b0;
      read_req_q  <= 1'b0;
      pass_cnt_q  <= '0;
      err_cnt_q   <= '0;
      status_q    <= 2'd0;
      done_q      <= 1'b0;
      busy_seen_q <= 1'b0;
      mism_q      <= 1'b0;
      ack_tmr_q   <= '0;
      op_tmr_q    <= '0;
`ifdef FLASH_SEQ_READLOOP_EN
      loop_q      <= 1'b0;
`endif
    end else begin
      erase_req_q <= 1'b0;
      prog_req_q  <= 1'b0;
      read_req_q  <= 1'b0;
      if (ack_tmr_q != '0) ack_tmr_q <= ack_tmr_q - ACK_W'(1);
      if (op_tmr_q != '0)  op_tmr_q  <= op_tmr_q - TO_W'(1);

      if (abort) begin
        state_q  <= S_IDLE;
        sector_q <= BASE_A;
        done_q   <= 1'b0;
`ifdef FLASH_SEQ_READLOOP_EN
        loop_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              pass_cnt_q  <= '0;
              err_cnt_q   <= '0;
              status_q    <= 2'd0;
              done_q      <= 1'b0;
              sector_q    <= BASE_A;
              state_q     <= S_ERASE;
              erase_req_q <= 1'b1;
`ifdef FLASH_SEQ_READLOOP_EN
              loop_q      <= 1'b0;
`endif
            end
          end

          S_ERASE, S_PROG, S_READ: begin
            state_q     <= (state_q == S_ERASE) ? S_ERASE_W :
                           (state_q == S_PROG)  ? S_PROG_W  : S_READ_W;
            busy_seen_q <= 1'b0;
            ack_tmr_q   <= ACK_LOAD;
            op_tmr_q    <= TO_LOAD;
          end

          S_ERASE_W, S_PROG_W, S_READ_W: begin
            if (busy_sel) busy_seen_q <= 1'b1;
            if (op_cmpl) begin
              if (state_q == S_ERASE_W) begin
                state_q    <= S_PROG;
                prog_req_q <= 1'b1;
              end else if (state_q == S_PROG_W) begin
                state_q    <= S_READ;
                read_req_q <= 1'b1;
              end else begin
                mism_q  <= rd_mismatch;
                state_q <= S_CHECK;
              end
            end else if (ack_expired) begin
              state_q  <= S_FAULT;
              status_q <= 2'd1;
            end else if (op_expired) begin
              state_q  <= S_FAULT;
              status_q <= 2'd2;
            end
          end

          S_CHECK: begin
            if (mism_q) begin
              if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
              if (pass_cnt_q != 16'hFFFF) pass_cnt_q <= pass_cnt_q + 16'd1;
            end
            state_q <= S_NEXT;
          end

          S_NEXT: begin
            if (sector_q < LAST_A) begin
              sector_q <= sector_q + ADDR_W'(1);
`ifdef FLASH_SEQ_READLOOP_EN
              if (loop_q) begin
                state_q    <= S_READ;
                read_req_q <= 1'b1;
              end else begin
                state_q     <= S_ERASE;
                erase_req_q <= 1'b1;
              end
`else
              state_q     <= S_ERASE;
              erase_req_q <= 1'b1;
`endif
            end else begin
`ifdef FLASH_SEQ_READLOOP_EN
              sector_q   <= BASE_A;
              loop_q     <= 1'b1;
              state_q    <= S_READ;
              read_req_q <= 1'b1;
`else
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              status_q <= (err_cnt_q != 16'd0) ? 2'd3 : 2'd0;
`endif
            end
          end

          S_FAULT: state_q <= S_FAULT;

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign erase_req = erase_req_q;
  assign prog_req  = prog_req_q;
  assign read_req  = read_req_q;
  assign sector    = sector_q;
  assign state     = state_q;
  assign pass_cnt  = pass_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign status    = status_q;
  assign done      = done_q;

endmodule

// File: tb/tb_flash_seq_ctrl.sv
// Directed bench for flash_seq_ctrl with a cycle-based model of the three flash engines.
`timescale 1ns/1ps
module tb_flash_seq_ctrl;
`ifdef FLASH_SEQ_READLOOP_EN
  localparam int LAST = 1;
`else
  localparam int LAST = 3;
`endif

  logic        CLK50M = 1'b0;
  logic        RST, start, abort;
  logic        erasing, proging, reading, rd_mismatch;
  logic        erase_req, prog_req, read_req, done;
  logic [11:0] sector;
  logic [3:0]  state;
  logic [15:0] pass_cnt, err_cnt;
  logic [1:0]  status;

  int n_checks = 0;
  int n_fail   = 0;

  // Engine model controls: mode 0 normal, 1 never acks, 2 acks and hangs busy;
  // the mode applies only to the request issued on sector mode_sec.
  int mode[3]     = '{0, 0, 0};
  int mode_sec[3] = '{0, 0, 0};
  bit eng_clear   = 1'b0;
  bit mm_en       = 1'b0;
  int mm_sec      = 0;
  int onehot_err  = 0;
  int log_eng[$];
  int log_sec[$];

  always #10 CLK50M = ~CLK50M;

  flash_seq_ctrl #(
    .ADDR_W(12), .BASE_ADDR(0), .LAST_ADDR(LAST), .ACK_CYC(16), .TIMEOUT_CYC(100)
  ) dut (
    .CLK50M(CLK50M), .RST(RST), .start(start), .abort(abort),
    .erase_req(erase_req), .erasing(erasing),
    .prog_req(prog_req), .proging(proging),
    .read_req(read_req), .reading(reading),
    .rd_mismatch(rd_mismatch), .sector(sector), .state(state),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .status(status), .done(done)
  );

  // Engines: busy rises 2 cycles after req, falls 10 cycles after req.
  initial begin
    int  age[3];
    int  emode[3];
    bit  act[3];
    logic [2:0] reqv;
    logic [2:0] bz;
    for (int e = 0; e < 3; e++) begin age[e] = 0; emode[e] = 0; act[e] = 1'b0; end
    erasing = 1'b0; proging = 1'b0; reading = 1'b0; rd_mismatch = 1'b0;
    forever begin
      @(posedge CLK50M);
      #1;
      reqv = {read_req, prog_req, erase_req};
      if ($countones(reqv) > 1) onehot_err++;
      for (int e = 0; e < 3; e++) begin
        if (!RST || eng_clear) begin
          act[e] = 1'b0;
        end else if (reqv[e]) begin
          act[e]   = 1'b1;
          age[e]   = 0;
          emode[e] = (mode[e] != 0 && int'(sector) == mode_sec[e]) ? mode[e] : 0;
          log_eng.push_back(e);
          log_sec.push_back(int'(sector));
        end else if (act[e]) begin
          age[e]++;
        end
        if (act[e] && emode[e] == 0 && age[e] >= 10) act[e] = 1'b0;
        bz[e] = act[e] && (emode[e] != 1) && (age[e] >= 2);
      end
      erasing     = bz[0];
      proging     = bz[1];
      reading     = bz[2];
      rd_mismatch = mm_en && (int'(sector) == mm_sec);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, state=%0d", state);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK50M);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort     = 1'b1;
    eng_clear = 1'b1;
    cyc(1);
    abort     = 1'b0;
    eng_clear = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state == s) begin ok = 1'b1; break; end
      cyc(1);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; abort = 1'b0;
    #5 RST = 1'b0;
    cyc(2);
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (sector !== 12'd0) begin n_fail++; $display("FAIL reset_sector: got %0d want 0", sector); end
    n_checks++; if ({erase_req, prog_req, read_req} !== 3'b000) begin n_fail++; $display("FAIL reset_reqs: got %b want 000", {erase_req, prog_req, read_req}); end
    n_checks++; if (pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters: got pass=%0d err=%0d want 0 0", pass_cnt, err_cnt); end
    n_checks++; if (status !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_status_done: got status=%0d done=%0d want 0 0", status, done); end
    RST = 1'b1;
    cyc(4);
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_release_idle: got %0d want 0", state); end
  endtask

  task automatic test_normal();
    bit ok;
    int base;
    base = log_eng.size();
    mm_en = 1'b0;
    pulse_start();
    wait_state(4'd9, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL normal_reach_done: state=%0d want 9", state); end
    n_checks++; if (log_eng.size() - base != 12) begin n_fail++; $display("FAIL normal_req_count: got %0d want 12", log_eng.size() - base); end
    for (int i = 0; i < 12 && base + i < log_eng.size(); i++) begin
      n_checks++;
      if (log_eng[base+i] != i % 3 || log_sec[base+i] != i / 3) begin
        n_fail++;
        $display("FAIL normal_req_order[%0d]: got eng=%0d sec=%0d want eng=%0d sec=%0d", i, log_eng[base+i], log_sec[base+i], i % 3, i / 3);
      end
    end
    n_checks++; if (pass_cnt !== 16'd4 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL normal_counts: got pass=%0d err=%0d want 4 0", pass_cnt, err_cnt); end
    n_checks++; if (done !== 1'b1 || status !== 2'd0) begin n_fail++; $display("FAIL normal_done_status: got done=%0d status=%0d want 1 0", done, status); end
    n_checks++; if (onehot_err != 0) begin n_fail++; $display("FAIL normal_onehot_req: got %0d overlapping cycles want 0", onehot_err); end
  endtask

  task automatic test_mismatch();
    bit ok;
    mm_en = 1'b1; mm_sec = 2;
    pulse_start();
    n_checks++; if (state !== 4'd1 || pass_cnt !== 16'd0 || done !== 1'b0) begin n_fail++; $display("FAIL mm_restart_clear: got state=%0d pass=%0d done=%0d want 1 0 0", state, pass_cnt, done); end
    wait_state(4'd9, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mm_reach_done: state=%0d want 9", state); end
    n_checks++; if (pass_cnt !== 16'd3 || err_cnt !== 16'd1) begin n_fail++; $display("FAIL mm_counts: got pass=%0d err=%0d want 3 1", pass_cnt, err_cnt); end
    n_checks++; if (status !== 2'd3 || done !== 1'b1) begin n_fail++; $display("FAIL mm_status: got status=%0d done=%0d want 3 1", status, done); end
    mm_en = 1'b0;
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int n;
    mode[1] = 1; mode_sec[1] = 2;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (prog_req === 1'b1 && sector == 12'd2) begin ok = 1'b1; break; end
      cyc(1);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ack_prog_req_seen: no prog_req on sector 2, state=%0d", state); end
    n = 0;
    while (state !== 4'd10 && n < 40) begin cyc(1); n++; end
    n_checks++; if (n != 16) begin n_fail++; $display("FAIL ack_fault_latency: got %0d cycles want 16", n); end
    n_checks++; if (status !== 2'd1 || sector !== 12'd2 || pass_cnt !== 16'd2) begin n_fail++; $display("FAIL ack_fault_regs: got status=%0d sector=%0d pass=%0d want 1 2 2", status, sector, pass_cnt); end
    pulse_start();
    cyc(4);
    n_checks++; if (state !== 4'd10 || sector !== 12'd2) begin n_fail++; $display("FAIL ack_start_ignored: got state=%0d sector=%0d want 10 2", state, sector); end
    pulse_abort();
    n_checks++; if (state !== 4'd0 || sector !== 12'd0 || pass_cnt !== 16'd2) begin n_fail++; $display("FAIL ack_abort_idle: got state=%0d sector=%0d pass=%0d want 0 0 2", state, sector, pass_cnt); end
    mode[1] = 0;
  endtask

  task automatic test_op_timeout();
    bit ok;
    int n;
    mode[2] = 2; mode_sec[2] = 0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (read_req === 1'b1) begin ok = 1'b1; break; end
      cyc(1);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL op_read_req_seen: no read_req, state=%0d", state); end
    n = 0;
    while (state !== 4'd10 && n < 150) begin cyc(1); n++; end
    n_checks++; if (n != 100) begin n_fail++; $display("FAIL op_fault_latency: got %0d cycles want 100", n); end
    n_checks++; if (status !== 2'd2) begin n_fail++; $display("FAIL op_fault_status: got %0d want 2", status); end
    pulse_abort();
    mode[2] = 0;
    n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL op_abort_idle: got %0d want 0", state); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (state == 4'd4 && sector == 12'd1) begin ok = 1'b1; break; end
      cyc(1);
    end
    n_checks++; if (!ok || pass_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_mid_setup: got state=%0d sector=%0d pass=%0d want 4 1 1", state, sector, pass_cnt); end
    #3 RST = 1'b0;
    #1;
    n_checks++; if (state !== 4'd0 || sector !== 12'd0) begin n_fail++; $display("FAIL rst_mid_async: got state=%0d sector=%0d want 0 0", state, sector); end
    n_checks++; if (pass_cnt !== 16'd0 || {erase_req, prog_req, read_req} !== 3'b000 || done !== 1'b0 || status !== 2'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got pass=%0d reqs=%b done=%0d status=%0d want 0 000 0 0", pass_cnt, {erase_req, prog_req, read_req}, done, status); end
    cyc(2);
    RST = 1'b1;
    cyc(4);
    base = log_eng.size();
    pulse_start();
    wait_state(4'd9, 1000, ok);
    n_checks++; if (!ok || log_eng.size() <= base) begin n_fail++; $display("FAIL rst_mid_restart_done: state=%0d want 9", state); end
    else begin
      n_checks++; if (log_eng[base] != 0 || log_sec[base] != 0) begin n_fail++; $display("FAIL rst_mid_first_req: got eng=%0d sec=%0d want 0 0", log_eng[base], log_sec[base]); end
    end
    n_checks++; if (pass_cnt !== 16'd4) begin n_fail++; $display("FAIL rst_mid_pass: got %0d want 4", pass_cnt); end
  endtask

  task automatic test_readloop();
    int exp_e[10] = '{0, 1, 2, 0, 1, 2, 2, 2, 2, 2};
    int exp_s[10] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1};
    bit ok;
    int base;
    base = log_eng.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (log_eng.size() - base >= 10) begin ok = 1'b1; break; end
      cyc(1);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loop_req_count: got %0d want 10", log_eng.size() - base); end
    for (int i = 0; i < 10 && base + i < log_eng.size(); i++) begin
      n_checks++;
      if (log_eng[base+i] != exp_e[i] || log_sec[base+i] != exp_s[i]) begin
        n_fail++;
        $display("FAIL loop_req_order[%0d]: got eng=%0d sec=%0d want eng=%0d sec=%0d", i, log_eng[base+i], log_sec[base+i], exp_e[i], exp_s[i]);
      end
    end
    n_checks++; if (pass_cnt !== 16'd5 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL loop_counts: got pass=%0d err=%0d want 5 0", pass_cnt, err_cnt); end
    n_checks++; if (done !== 1'b0 || state !== 4'd5) begin n_fail++; $display("FAIL loop_not_done: got done=%0d state=%0d want 0 5", done, state); end
  endtask

  initial begin
    test_reset();
`ifdef FLASH_SEQ_READLOOP_EN
    test_readloop();
`else
    test_normal();
    test_mismatch();
    test_ack_timeout();
    test_op_timeout();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
